cache_assoc_ctrl: RTL and testbench

- Parametrised N-way set-associative, write-back, write-allocate data cache with an integrated miss/eviction FSM.
- Sits between the MEM stage and the memory arbiter.
- Successor to the direct-mapped cache wrapper. Adds:
  - configurable ways and sets
  - per-set round-robin replacement
  - halfword access
  - misalignment detection
  - an explicit request/grant memory handshake with separate evict and fill phases

---
 rtl/cache_assoc_ctrl.sv | 157 +++++++++++++++
 tb/tb_cache_assoc_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_assoc_ctrl.sv
// cache_assoc_ctrl: N-way set-associative write-back data cache with miss/evict FSM
module cache_assoc_ctrl #(
    parameter int NUM_SETS   = 4,
    parameter int NUM_WAYS   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int XLEN       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_load,
    input  logic                  req_store,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic [XLEN-1:0]       req_wdata,
    output logic [XLEN-1:0]       read_data,
    output logic                  stall,
    output logic                  misaligned,
    output logic                  mem_req,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [LINE_WIDTH-1:0] mem_req_data,
    input  logic                  mem_grant,
    input  logic                  mem_resp,
    input  logic [ADDR_WIDTH-1:0] mem_resp_addr,
    input  logic [LINE_WIDTH-1:0] mem_resp_data
);
    localparam int OFF = $clog2(LINE_WIDTH / 8);
    localparam int IB  = $clog2(NUM_SETS);
    localparam int IW  = IB > 0 ? IB : 1;
    localparam int WW  = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;
    localparam int TW  = ADDR_WIDTH - OFF - IB;

    typedef enum logic [1:0] {IDLE, EVICT, FILL_REQ, FILL_WAIT} state_t;

    state_t                state, state_nxt;
    logic                  valid [NUM_SETS][NUM_WAYS];
    logic                  dirty [NUM_SETS][NUM_WAYS];
    logic [TW-1:0]         tags  [NUM_SETS][NUM_WAYS];
    logic [LINE_WIDTH-1:0] lines [NUM_SETS][NUM_WAYS];
    logic [WW-1:0]         rr    [NUM_SETS];
    logic [WW-1:0]         victim, victim_q, hit_way;
    logic                  hit, access, store_hit, evict_done, fill_done;
    logic [IW-1:0]         idx;
    logic [TW-1:0]         tag;
    logic [OFF-1:0]        off;
    logic [ADDR_WIDTH-1:0] line_addr;
    logic [LINE_WIDTH-1:0] cur_line, lane_mask, store_line;

    assign line_addr  = (req_addr >> OFF) << OFF;
    assign idx        = IW'((req_addr >> OFF) & ADDR_WIDTH'(NUM_SETS - 1));
    assign tag        = TW'(req_addr >> (OFF + IB));
    assign off        = req_addr[OFF-1:0];
    assign misaligned = req_valid & (req_load | req_store) &
                        ((req_size == 2'd1 & req_addr[0]) | (req_size[1] & |req_addr[1:0]));
    assign access     = req_valid & (req_load | req_store) & ~misaligned;

    // Tag lookup; descending scan leaves the lowest invalid way as victim
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        victim  = rr[idx];
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid[idx][w]) victim = WW'(w);
            if (valid[idx][w] && tags[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        end
    end

    // Lane selection for load extraction and store merge
    always_comb begin
        cur_line   = lines[idx][hit_way];
        lane_mask  = (req_size == 2'd0 ? LINE_WIDTH'(8'hff) :
                      req_size == 2'd1 ? LINE_WIDTH'(16'hffff) :
                                         LINE_WIDTH'({XLEN{1'b1}})) << {off, 3'b000};
        store_line = (cur_line & ~lane_mask) | ((LINE_WIDTH'(req_wdata) << {off, 3'b000}) & lane_mask);
        read_data  = (state == IDLE && access && req_load && hit) ?
                     XLEN'((cur_line & lane_mask) >> {off, 3'b000}) : '0;
    end

    // Miss FSM next state and memory-side outputs
    always_comb begin
        state_nxt     = state;
        stall         = 1'b0;
        mem_req       = 1'b0;
        mem_req_write = 1'b0;
        mem_req_addr  = line_addr;
        mem_req_data  = lines[idx][victim_q];
        store_hit     = 1'b0;
        evict_done    = 1'b0;
        fill_done     = 1'b0;
        case (state)
            IDLE: begin
                store_hit = access & req_store & hit;
                if (access && !hit) begin
                    stall     = 1'b1;
                    state_nxt = (valid[idx][victim] && dirty[idx][victim]) ? EVICT : FILL_REQ;
                end
            end
            EVICT: begin
                stall         = 1'b1;
                mem_req       = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = (ADDR_WIDTH'(tags[idx][victim_q]) << (OFF + IB)) | (ADDR_WIDTH'(idx) << OFF);
                evict_done    = mem_grant;
                state_nxt     = mem_grant ? FILL_REQ : EVICT;
            end
            FILL_REQ: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                state_nxt = mem_grant ? FILL_WAIT : FILL_REQ;
            end
            default: begin
                stall     = 1'b1;
                fill_done = mem_resp & (mem_resp_addr == line_addr);
                state_nxt = fill_done ? IDLE : FILL_WAIT;
            end
        endcase
    end

    // State register plus valid/dirty/replacement metadata
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            victim_q <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                rr[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid[s][w] <= 1'b0;
                    dirty[s][w] <= 1'b0;
                end
            end
        end else begin
            state <= state_nxt;
            if (state == IDLE) victim_q <= victim;
            if (store_hit) dirty[idx][hit_way] <= 1'b1;
            if (evict_done) dirty[idx][victim_q] <= 1'b0;
            if (fill_done) begin
                valid[idx][victim_q] <= 1'b1;
                dirty[idx][victim_q] <= 1'b0;
                rr[idx]              <= NUM_WAYS > 1 ? rr[idx] + WW'(1) : '0;
            end
        end
    end

    // Line data and tags are never cleared; valid bits gate their use
    always_ff @(posedge clk) begin
        if (reset && store_hit) lines[idx][hit_way] <= store_line;
        if (reset && fill_done) begin
            lines[idx][victim_q] <= mem_resp_data;
            tags[idx][victim_q]  <= tag;
        end
    end
endmodule

// File: tb/tb_cache_assoc_ctrl.sv
// tb_cache_assoc_ctrl: random and directed checks against a cache/memory reference model
module tb_cache_assoc_ctrl;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req_valid = 1'b0, req_load = 1'b0, req_store = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [1:0]   req_size = '0;
    logic [31:0]  req_wdata = '0;
    logic [31:0]  read_data;
    logic         stall, misaligned, mem_req, mem_req_write;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic         mem_grant = 1'b0, mem_resp = 1'b0;
    logic [31:0]  mem_resp_addr = '0;
    logic [127:0] mem_resp_data = '0;

    int checks = 0;
    int errors = 0;

    // reference model: 4 sets x 2 ways, 16-byte lines, plus backing memory
    bit           mv [4][2];
    bit           md [4][2];
    logic [25:0]  mt [4][2];
    logic [127:0] ml [4][2];
    int           rrp[4];
    logic [127:0] mem [logic [31:0]];

    cache_assoc_ctrl dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_load(req_load),
        .req_store(req_store), .req_addr(req_addr), .req_size(req_size),
        .req_wdata(req_wdata), .read_data(read_data), .stall(stall),
        .misaligned(misaligned), .mem_req(mem_req), .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_grant(mem_grant),
        .mem_resp(mem_resp), .mem_resp_addr(mem_resp_addr), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : {a * 3 + 32'h1, ~a, a ^ 32'hA5A55A5A, a + 32'h1234};
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    endfunction

    function automatic logic [31:0] exp_read(input logic [127:0] line, input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] r = '0;
        for (int b = 0; b < nbytes(sz); b++) r[b*8 +: 8] = line[(int'(a[3:0]) + b) * 8 +: 8];
        return r;
    endfunction

    function automatic logic [127:0] merge(input logic [127:0] line, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        logic [127:0] l = line;
        for (int b = 0; b < nbytes(sz); b++) l[(int'(a[3:0]) + b) * 8 +: 8] = wd[b*8 +: 8];
        return l;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            rrp[s] = 0;
            for (int w = 0; w < 2; w++) begin
                mv[s][w] = 0;
                md[s][w] = 0;
            end
        end
    endtask

    // one core access, serving the memory side and checking everything along the way
    task automatic access(input bit st, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                          output logic [31:0] rd, output bit missed);
        int s, v, hw, n, exp_n, d;
        bit mis, ev;
        logic [25:0] t;
        logic [31:0] la, ea;
        s = int'((a >> 4) & 32'h3);
        t = 26'(a >> 6);
        la = a & ~32'hF;
        missed = 0;
        rd = '0;
        mis = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'b00);
        @(negedge clk);
        req_valid = 1; req_load = !st; req_store = st; req_addr = a; req_size = sz; req_wdata = wd;
        mem_grant = 0; mem_resp = 0;
        #1;
        check("misaligned", misaligned, mis);
        if (mis) begin
            check("mis_stall", stall, 0);
            check("mis_memreq", mem_req, 0);
            check("mis_rdata", read_data, 0);
            return;
        end
        hw = -1;
        for (int w = 0; w < 2; w++) if (mv[s][w] && mt[s][w] == t) hw = w;
        if (hw < 0) begin
            missed = 1;
            n = 0;
            exp_n = 3;
            check("miss_stall", stall, 1);
            check("miss_noreq", mem_req, 0);
            v = -1;
            for (int w = 1; w >= 0; w--) if (!mv[s][w]) v = w;
            if (v < 0) v = rrp[s];
            ev = mv[s][v] && md[s][v];
            if (ev) begin
                ea = {mt[s][v], 2'(s), 4'h0};
                d = $urandom_range(0, 2);
                exp_n += 1 + d;
                for (int k = 0; k <= d; k++) begin
                    @(negedge clk); n++;
                    mem_grant = (k == d);
                    #1;
                    check("wb_req", mem_req, 1);
                    check("wb_write", mem_req_write, 1);
                    check("wb_addr", mem_req_addr, ea);
                    check("wb_data", mem_req_data, ml[s][v]);
                    check("wb_stall", stall, 1);
                end
                mem[ea] = ml[s][v];
                md[s][v] = 0;
            end
            d = $urandom_range(0, 2);
            exp_n += d;
            for (int k = 0; k <= d; k++) begin
                @(negedge clk); n++;
                mem_grant = (k == d);
                mem_resp = 1'($urandom_range(0, 1));
                mem_resp_addr = la;
                mem_resp_data = {4{$urandom}};
                #1;
                check("fill_req", mem_req, 1);
                check("fill_write", mem_req_write, 0);
                check("fill_addr", mem_req_addr, la);
                check("fill_stall", stall, 1);
            end
            d = $urandom_range(0, 2);
            exp_n += d;
            for (int k = 0; k < d; k++) begin
                @(negedge clk); n++;
                mem_grant = 1'($urandom_range(0, 1));
                mem_resp = 1'($urandom_range(0, 1));
                mem_resp_addr = la ^ 32'h40;
                mem_resp_data = {4{$urandom}};
                #1;
                check("wait_stall", stall, 1);
                check("wait_noreq", mem_req, 0);
            end
            @(negedge clk); n++;
            mem_grant = 0; mem_resp = 1; mem_resp_addr = la; mem_resp_data = mem_rd(la);
            #1;
            check("resp_stall", stall, 1);
            mv[s][v] = 1; md[s][v] = 0; mt[s][v] = t; ml[s][v] = mem_rd(la);
            rrp[s] = (rrp[s] + 1) % 2;
            hw = v;
            @(negedge clk); n++;
            mem_resp = 0;
            #1;
            check("latency", n, exp_n);
        end
        check("hit_stall", stall, 0);
        if (!st) begin
            rd = read_data;
            check("load_data", read_data, exp_read(ml[s][hw], a, sz));
        end else begin
            ml[s][hw] = merge(ml[s][hw], a, sz, wd);
            md[s][hw] = 1;
        end
    endtask

    initial begin
        logic [31:0] rd;
        bit missed;
        model_reset();
        mem[32'h100] = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", stall, 0);
        check("rst_memreq", mem_req, 0);
        check("rst_memwr", mem_req_write, 0);
        check("rst_rdata", read_data, 0);
        check("rst_misal", misaligned, 0);
        reset = 1;

        access(0, 32'h100, 2'd2, 0, rd, missed);
        check("tp_fill_miss", missed, 1);
        check("tp_fill_word", rd, 32'hDEADBEEF);
        access(1, 32'h103, 2'd0, 32'hAB, rd, missed);
        check("tp_store_hit", missed, 0);
        access(0, 32'h100, 2'd2, 0, rd, missed);
        check("tp_merged_word", rd, 32'hABADBEEF);
        access(0, 32'h102, 2'd1, 0, rd, missed);
        check("tp_half", rd, 32'h0000ABAD);
        access(0, 32'h140, 2'd2, 0, rd, missed);
        check("tp_140_miss", missed, 1);
        access(0, 32'h180, 2'd2, 0, rd, missed);
        check("tp_180_miss", missed, 1);
        check("tp_wb_mem", mem[32'h100][31:0], 32'hABADBEEF);
        access(0, 32'h140, 2'd2, 0, rd, missed);
        check("tp_140_hit", missed, 0);
        access(0, 32'h101, 2'd1, 0, rd, missed);
        access(1, 32'h102, 2'd2, 32'h12345678, rd, missed);

        // abort a fill with reset after an ignored mismatched response
        @(negedge clk);
        req_valid = 1; req_load = 1; req_store = 0; req_addr = 32'h100; req_size = 2'd2;
        #1;
        check("ab_stall", stall, 1);
        @(negedge clk);
        mem_grant = 1;
        #1;
        check("ab_fill_req", mem_req, 1);
        check("ab_fill_addr", mem_req_addr, 32'h100);
        @(negedge clk);
        mem_grant = 0; mem_resp = 1; mem_resp_addr = 32'h200; mem_resp_data = {4{32'hBAD0BAD0}};
        #1;
        check("ab_mismatch_stall", stall, 1);
        @(negedge clk);
        mem_resp = 0;
        #1;
        check("ab_still_wait", stall, 1);
        reset = 0; req_valid = 0;
        @(negedge clk);
        reset = 1;
        #1;
        check("ab_memreq", mem_req, 0);
        check("ab_idle_stall", stall, 0);
        @(negedge clk);
        mem_resp = 1; mem_resp_addr = 32'h100; mem_resp_data = {4{32'h5EED5EED}};
        @(negedge clk);
        mem_resp = 0;
        model_reset();
        access(0, 32'h100, 2'd2, 0, rd, missed);
        check("ab_late_resp_miss", missed, 1);

        for (int i = 0; i < 300; i++) begin
            access(1'($urandom_range(0, 1)), 32'h100 + ($urandom_range(0, 15) << 4) + $urandom_range(0, 15),
                   2'($urandom_range(0, 3)), $urandom, rd, missed);
        end
        @(negedge clk);
        req_valid = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
